// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one outstanding read at a time to
// instruction memory using the current PC, pulses pc_inc on a completed
// fetch and queues {pc, instruction} pairs in a small FWFT FIFO for decode.
// A flush discards buffered entries and any fetch still in flight.
module instruction_fetch #(
  parameter int DEPTH      = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] pc_in,
  output logic                  pc_inc,
  input  logic                  flush,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DISCARD
  } state_t;

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] instr_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]      rd_ptr, wr_ptr;
  logic [PTR_W:0]        count;

  logic full;
  logic issue;
  logic push;
  logic pop;
  logic done;

  assign full        = (count == FULL_CNT);
  assign instr_valid = (count != '0);
  assign instr       = instr_mem[rd_ptr];
  assign instr_pc    = pc_mem[rd_ptr];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: a request stays outstanding until acked, even across a flush
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (!flush && !full) begin
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          state_nxt = S_IDLE;
        end else if (flush) begin
          state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (mem_ack) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Control outputs: pc_inc is suppressed on flush since the PC favours increment over load
  always_comb begin
    issue  = (state == S_IDLE) && !flush && !full;
    push   = (state == S_WAIT) && mem_ack && !flush;
    done   = (state != S_IDLE) && mem_ack;
    pc_inc = push;
    pop    = instr_valid && instr_ready && !flush;
  end

  // Memory request register; address is held for the whole request
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_req  <= 1'b0;
      mem_addr <= '0;
    end else if (issue) begin
      mem_req  <= 1'b1;
      mem_addr <= pc_in;
    end else if (done) begin
      mem_req  <= 1'b0;
    end
  end

  // FIFO storage; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= mem_rdata;
      pc_mem[wr_ptr]    <= mem_addr;
    end
  end

  // FIFO pointers and occupancy; flush wins over push and pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a behavioural PC and a
// fixed-latency instruction memory.
module tb_instruction_fetch;

  localparam int DEPTH = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk;
  logic          reset;
  logic          pc_clr;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic [AW-1:0] pc;
  logic          pc_inc;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          instr_valid;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic          instr_ready;
  logic [3:0]    lat;
  logic [3:0]    wcnt;

  int n_chk;
  int n_err;

  instruction_fetch #(
    .DEPTH(DEPTH), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)
  ) dut (
    .clk(clk), .reset(reset), .pc_in(pc), .pc_inc(pc_inc), .flush(flush),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .instr_valid(instr_valid), .instr(instr),
    .instr_pc(instr_pc), .instr_ready(instr_ready)
  );

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC model: load on flush, otherwise advance on pc_inc
  always_ff @(posedge clk) begin
    if (pc_clr)      pc <= '0;
    else if (flush)  pc <= flush_pc;
    else if (pc_inc) pc <= pc + 1;
  end

  // Memory model: ack after lat cycles of mem_req
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    wcnt <= '0;
    else if (mem_req && !mem_ack) wcnt <= wcnt + 1'b1;
    else                          wcnt <= '0;
  end

  assign mem_ack   = mem_req && (wcnt == lat);
  assign mem_rdata = mem_ack ? mem_word(mem_addr) : '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic nc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    pc_clr = 1'b1;
    flush  = 1'b0;
    nc();
    nc();
    reset  = 1'b0;
    pc_clr = 1'b0;
  endtask

  initial begin
    n_chk       = 0;
    n_err       = 0;
    reset       = 1'b1;
    pc_clr      = 1'b1;
    flush       = 1'b0;
    flush_pc    = '0;
    instr_ready = 1'b1;
    lat         = 4'd0;

    // Reset state
    nc();
    nc();
    check_eq("rst_req",   mem_req,     1'b0);
    check_eq("rst_addr",  mem_addr,    32'h0);
    check_eq("rst_valid", instr_valid, 1'b0);
    check_eq("rst_inc",   pc_inc,      1'b0);
    reset  = 1'b0;
    pc_clr = 1'b0;

    // Zero-wait streaming: request every 2 cycles, addresses 0..3 in order
    for (int i = 0; i < 4; i++) begin
      nc();
      check_eq("zw_req",   mem_req,     1'b1);
      check_eq("zw_addr",  mem_addr,    i);
      check_eq("zw_inc",   pc_inc,      1'b1);
      check_eq("zw_vld0",  instr_valid, 1'b0);
      nc();
      check_eq("zw_req0",  mem_req,     1'b0);
      check_eq("zw_inc0",  pc_inc,      1'b0);
      check_eq("zw_vld",   instr_valid, 1'b1);
      check_eq("zw_ipc",   instr_pc,    i);
      check_eq("zw_instr", instr,       mem_word(i));
    end

    // Back-pressure fills the FIFO, then drains in order
    instr_ready = 1'b0;
    lat         = 4'd0;
    do_reset();
    nc();
    check_eq("bp_req_a",  mem_req,  1'b1);
    check_eq("bp_addr_a", mem_addr, 32'd0);
    nc();
    check_eq("bp_req_b",  mem_req,  1'b0);
    check_eq("bp_ipc_b",  instr_pc, 32'd0);
    nc();
    check_eq("bp_req_c",  mem_req,  1'b1);
    check_eq("bp_addr_c", mem_addr, 32'd1);
    check_eq("bp_inc_c",  pc_inc,   1'b1);
    nc();
    check_eq("bp_full_req", mem_req,     1'b0);
    check_eq("bp_full_vld", instr_valid, 1'b1);
    nc();
    check_eq("bp_hold_req",   mem_req,  1'b0);
    check_eq("bp_hold_ipc",   instr_pc, 32'd0);
    check_eq("bp_hold_instr", instr,    mem_word(32'd0));
    instr_ready = 1'b1;
    nc();
    check_eq("bp_pop1_ipc", instr_pc,    32'd1);
    check_eq("bp_pop1_vld", instr_valid, 1'b1);
    check_eq("bp_pop1_req", mem_req,     1'b0);
    nc();
    check_eq("bp_resume_req",  mem_req,     1'b1);
    check_eq("bp_resume_addr", mem_addr,    32'd2);
    check_eq("bp_resume_vld",  instr_valid, 1'b0);

    // Push and pop in the same cycle keep one entry; order preserved
    instr_ready = 1'b0;
    lat         = 4'd2;
    do_reset();
    nc();
    check_eq("pp_addr0", mem_addr, 32'd0);
    check_eq("pp_inc_w", pc_inc,   1'b0);
    nc();
    nc();
    check_eq("pp_inc_a", pc_inc, 1'b1);
    nc();
    check_eq("pp_vld0", instr_valid, 1'b1);
    check_eq("pp_req0", mem_req,     1'b0);
    nc();
    check_eq("pp_addr1", mem_addr, 32'd1);
    check_eq("pp_ipc0",  instr_pc, 32'd0);
    nc();
    nc();
    check_eq("pp_inc_b", pc_inc, 1'b1);
    instr_ready = 1'b1;
    nc();
    check_eq("pp_vld1",   instr_valid, 1'b1);
    check_eq("pp_ipc1",   instr_pc,    32'd1);
    check_eq("pp_instr1", instr,       mem_word(32'd1));
    nc();
    check_eq("pp_empty", instr_valid, 1'b0);
    check_eq("pp_addr2", mem_addr,    32'd2);

    // Flush in first WAIT cycle with slow memory: request held, data dropped
    instr_ready = 1'b1;
    lat         = 4'd3;
    do_reset();
    nc();
    check_eq("fw_req",  mem_req,  1'b1);
    check_eq("fw_addr", mem_addr, 32'd0);
    flush    = 1'b1;
    flush_pc = 32'h40;
    #1;
    check_eq("fw_inc_flush", pc_inc, 1'b0);
    nc();
    flush = 1'b0;
    check_eq("fw_hold_req",  mem_req,  1'b1);
    check_eq("fw_hold_addr", mem_addr, 32'd0);
    nc();
    flush = 1'b1;
    check_eq("fw_req_c", mem_req, 1'b1);
    nc();
    flush = 1'b0;
    check_eq("fw_ack_inc", pc_inc,  1'b0);
    check_eq("fw_ack_req", mem_req, 1'b1);
    nc();
    check_eq("fw_idle_req", mem_req,     1'b0);
    check_eq("fw_idle_vld", instr_valid, 1'b0);
    nc();
    check_eq("fw_new_req",  mem_req,     1'b1);
    check_eq("fw_new_addr", mem_addr,    32'h40);
    check_eq("fw_new_vld",  instr_valid, 1'b0);

    // Flush coincident with ack
    lat = 4'd1;
    do_reset();
    nc();
    check_eq("fa_addr", mem_addr, 32'd0);
    nc();
    check_eq("fa_inc_pre", pc_inc, 1'b1);
    flush    = 1'b1;
    flush_pc = 32'h20;
    #1;
    check_eq("fa_inc_flush", pc_inc, 1'b0);
    nc();
    flush = 1'b0;
    check_eq("fa_vld", instr_valid, 1'b0);
    check_eq("fa_req", mem_req,     1'b0);
    nc();
    check_eq("fa_new_addr", mem_addr, 32'h20);
    nc();
    check_eq("fa_new_inc", pc_inc, 1'b1);
    nc();
    check_eq("fa_vld2",   instr_valid, 1'b1);
    check_eq("fa_ipc",    instr_pc,    32'h20);
    check_eq("fa_instr",  instr,       mem_word(32'h20));

    // Asynchronous reset in the middle of a request
    instr_ready = 1'b0;
    lat         = 4'd0;
    do_reset();
    nc();
    check_eq("ar_inc", pc_inc, 1'b1);
    nc();
    lat = 4'd3;
    check_eq("ar_vld_a", instr_valid, 1'b1);
    nc();
    check_eq("ar_req_a",  mem_req,     1'b1);
    check_eq("ar_addr_a", mem_addr,    32'd1);
    check_eq("ar_vld_b",  instr_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_req_drop", mem_req,     1'b0);
    check_eq("ar_vld_drop", instr_valid, 1'b0);
    check_eq("ar_inc_rst",  pc_inc,      1'b0);
    nc();
    check_eq("ar_addr_rst", mem_addr, 32'd0);
    reset = 1'b0;
    nc();
    check_eq("ar_new_req",  mem_req,  1'b1);
    check_eq("ar_new_addr", mem_addr, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
